seq_detect_fsm: RTL and testbench

SEQ_DETECT_FSM -- requirements
Module: seq_detect_fsm

---
 rtl/seq_detect_fsm_if.sv | 27 ++
 rtl/seq_detect_fsm.sv | 77 +++++++
 tb/tb_seq_detect_fsm.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_fsm_if.sv
// Bundles the serial-detector control, data and status signals.
// The bench drives through master; the detector attaches as slave.
interface seq_detect_fsm_if #(
  parameter int p_nbits = 4,
  parameter int p_cntw  = 8
);
  localparam int sw = $clog2(p_nbits + 1);

  logic               in_;
  logic               en;
  logic               load;
  logic [p_nbits-1:0] pattern;
  logic               overlap;
  logic [sw-1:0]      state;
  logic               match;
  logic [p_cntw-1:0]  count;

  modport master (
    output in_, en, load, pattern, overlap,
    input  state, match, count
  );

  modport slave (
    input  in_, en, load, pattern, overlap,
    output state, match, count
  );
endinterface

// File: rtl/seq_detect_fsm.sv
// Runtime-programmable serial pattern detector. The state is the number of pattern bits
// currently matched; transitions are computed on the fly against the loaded pattern.
module seq_detect_fsm #(
  parameter int p_nbits = 4,
  parameter int p_cntw  = 8
) (
  input logic             clk,
  input logic             reset,
  seq_detect_fsm_if.slave bus
);
  localparam int sw = $clog2(p_nbits + 1);
  localparam int w  = p_nbits + 1;

  typedef logic [sw-1:0] state_t;
  localparam state_t s_full = state_t'(p_nbits);

  // Longest prefix of p that is a suffix of (first k pattern bits, then b).
  // The string is held LSB = newest bit, so suffix/prefix compares become masked XORs.
  function automatic state_t delta(input state_t k, input logic b, input logic [p_nbits-1:0] p);
    logic [w-1:0] pw;
    logic [w-1:0] str;
    logic [w-1:0] pre;
    logic [w-1:0] mask;
    state_t       best;
    pw   = {1'b0, p};
    str  = ((pw >> (p_nbits - int'(k))) << 1) | w'(b);
    best = '0;
    for (int j = 1; j <= p_nbits; j++) begin
      pre  = pw >> (p_nbits - j);
      mask = w'((1 << j) - 1);
      if ((j <= int'(k) + 1) && (((str ^ pre) & mask) == '0)) begin
        best = state_t'(j);
      end
    end
    return best;
  endfunction

  logic [p_nbits-1:0] p_reg;
  state_t             s_reg;
  state_t             s_next;
  logic               match_reg;
  logic [p_cntw-1:0]  count_reg;

  // Leaving a full match without overlap restarts from an empty history.
  always_comb begin
    s_next = '0;
    if ((s_reg == s_full) && !bus.overlap) begin
      s_next = delta('0, bus.in_, p_reg);
    end else begin
      s_next = delta(s_reg, bus.in_, p_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_reg     <= '0;
      s_reg     <= '0;
      match_reg <= 1'b0;
      count_reg <= '0;
    end else if (bus.load) begin
      p_reg     <= bus.pattern;
      s_reg     <= '0;
      match_reg <= 1'b0;
      count_reg <= '0;
    end else if (bus.en) begin
      s_reg     <= s_next;
      match_reg <= (s_next == s_full);
      if ((s_next == s_full) && (count_reg != '1)) begin
        count_reg <= count_reg + p_cntw'(1);
      end
    end
  end

  assign bus.state = s_reg;
  assign bus.match = match_reg;
  assign bus.count = count_reg;
endmodule

// File: tb/tb_seq_detect_fsm.sv
// Scoreboarded bench: the driver pushes model expectations per cycle, the monitor pops and
// compares after each clock edge; spot checks against fixed values cover the key scenarios.
module tb_seq_detect_fsm;
  localparam int N  = 4;
  localparam int CW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seq_detect_fsm_if #(.p_nbits(N), .p_cntw(CW)) bus ();

  seq_detect_fsm #(.p_nbits(N), .p_cntw(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int state;
    bit match;
    int count;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_txn    = 0;

  // Reference model: pattern bits in time order plus the recent consumed history.
  bit m_pat[N];
  bit hist[$];
  int m_count = 0;

  function automatic int model_state();
    int best;
    bit ok;
    best = 0;
    for (int j = 1; j <= N; j++) begin
      if (j <= hist.size()) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          if (hist[hist.size() - j + i] != m_pat[i]) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  task automatic step(input bit r, input bit ld, input logic [N-1:0] pat,
                      input bit e, input bit b, input bit ov);
    exp_t x;
    @(posedge clk);
    #1;
    reset       = r;
    bus.load    = ld;
    bus.pattern = pat;
    bus.en      = e;
    bus.in_     = b;
    bus.overlap = ov;
    if (r) begin
      for (int i = 0; i < N; i++) m_pat[i] = 1'b0;
      hist.delete();
      m_count = 0;
    end else if (ld) begin
      for (int i = 0; i < N; i++) m_pat[i] = pat[N-1-i];
      hist.delete();
      m_count = 0;
    end else if (e) begin
      if (model_state() == N && !ov) hist.delete();
      hist.push_back(b);
      if (hist.size() > N) void'(hist.pop_front());
      if (model_state() == N && m_count < (2**CW) - 1) m_count++;
    end
    x.state = model_state();
    x.match = (x.state == N);
    x.count = m_count;
    exp_q.push_back(x);
  endtask

  task automatic feed(input logic [31:0] val, input int len, input bit ov);
    for (int i = len - 1; i >= 0; i--) step(1'b0, 1'b0, '0, 1'b1, val[i], ov);
  endtask

  // Idle cycle, then compare the outputs produced by the previously applied inputs.
  task automatic spec_check(input string name, input int s, input bit m, input int c);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (int'(bus.state) == s && bus.match == m && int'(bus.count) == c) begin
      n_pass++;
      $display("check %s: state=%0d match=%0d count=%0d ok", name, bus.state, bus.match, bus.count);
    end else begin
      $display("FAIL %s: got state=%0d match=%0d count=%0d, want state=%0d match=%0d count=%0d",
               name, bus.state, bus.match, bus.count, s, m, c);
    end
  endtask

  // Monitor: every edge that follows a pushed stimulus yields one output to compare.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        #2;
        x = exp_q.pop_front();
        n_txn++;
        n_checks++;
        if (int'(bus.state) == x.state && bus.match == x.match && int'(bus.count) == x.count) begin
          n_pass++;
          $display("txn %0d: state=%0d match=%0d count=%0d", n_txn, bus.state, bus.match, bus.count);
        end else begin
          $display("FAIL scoreboard txn %0d: got state=%0d match=%0d count=%0d, want state=%0d match=%0d count=%0d",
                   n_txn, bus.state, bus.match, bus.count, x.state, x.match, x.count);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    bus.in_     = 1'b0;
    bus.en      = 1'b0;
    bus.load    = 1'b0;
    bus.pattern = '0;
    bus.overlap = 1'b0;

    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    spec_check("reset_state", 0, 1'b0, 0);

    // Overlapping detection of 1011 on 1011011
    step(1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
    feed(32'b1011, 4, 1'b1);
    spec_check("ovl_bit4", 4, 1'b1, 1);
    feed(32'b0, 1, 1'b1);
    spec_check("ovl_bit5", 2, 1'b0, 1);
    feed(32'b11, 2, 1'b1);
    spec_check("ovl_bit7", 4, 1'b1, 2);

    // Non-overlapping on the same stream
    step(1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
    feed(32'b1011, 4, 1'b0);
    spec_check("novl_bit4", 4, 1'b1, 1);
    feed(32'b011, 3, 1'b0);
    spec_check("novl_bit7", 1, 1'b0, 1);

    // All-ones pattern, continuous match and counter saturation
    step(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
    feed(32'b111, 3, 1'b1);
    spec_check("ones_bit3", 3, 1'b0, 0);
    feed(32'b1, 1, 1'b1);
    spec_check("ones_bit4", 4, 1'b1, 1);
    for (int i = 0; i < 296; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    spec_check("ones_saturate", 4, 1'b1, 255);

    // Stall with in_ toggling holds the partial match
    step(1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
    feed(32'b101, 3, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    spec_check("stall_hold", 3, 1'b0, 0);
    feed(32'b1, 1, 1'b1);
    spec_check("stall_resume", 4, 1'b1, 1);

    // Load mid-match restarts with the new pattern
    step(1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
    feed(32'b101, 3, 1'b1);
    spec_check("pre_load", 3, 1'b0, 0);
    step(1'b0, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b1);
    spec_check("load_restart", 0, 1'b0, 0);
    feed(32'b0110, 4, 1'b1);
    spec_check("new_pattern", 4, 1'b1, 1);

    // Reset mid-stream clears everything, including the pattern
    step(1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
    feed(32'b1011011011011011, 16, 1'b1);
    feed(32'b101, 3, 1'b1);
    spec_check("pre_reset", 3, 1'b0, 5);
    step(1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
    spec_check("reset_mid", 0, 1'b0, 0);
    feed(32'b0000, 4, 1'b1);
    spec_check("zero_pattern", 4, 1'b1, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0, N'($urandom),
           $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom));
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
